// File: rtl/mvu_pkg.sv
// Shared types for the MVU job dispatcher: descriptor, config broadcast, completion
// record and the per-MVU slot state.
package mvu_pkg;

   localparam int N      = 8;
   localparam int ADDR_W = 15;
   localparam int CNT_W  = 15;
   localparam int TAG_W  = 4;
   localparam int ID_W   = 4;
   localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
   localparam int BAD_ID = N;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_PEND = 2'd2
   } slot_state_t;

   typedef struct packed {
      logic [3:0]        wprec;
      logic [3:0]        iprec;
      logic [3:0]        oprec;
      logic [ADDR_W-1:0] wbase;
      logic [ADDR_W-1:0] ibase;
      logic [ADDR_W-1:0] obase;
      logic [CNT_W-1:0]  countdown;
   } mvu_cfg_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [TAG_W-1:0]  tag;
      logic [3:0]        wprec;
      logic [3:0]        iprec;
      logic [3:0]        oprec;
      logic [ADDR_W-1:0] wbase;
      logic [ADDR_W-1:0] ibase;
      logic [ADDR_W-1:0] obase;
      logic [CNT_W-1:0]  countdown;
   } job_desc_t;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [TAG_W-1:0] tag;
      logic             err;
   } cpl_t;

endpackage

// File: rtl/mvu_dispatch_slot.sv
// Tracks one MVU's job: IDLE -> BUSY (start issued) -> PEND (irq or timeout) -> IDLE
// (completion taken by the output register). Holds the job tag and the error flag.
module mvu_dispatch_slot
   import mvu_pkg::*;
#(
   parameter int TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             accept,
   input  logic             irq,
   input  logic             pop,
   input  logic [TAG_W-1:0] tag_in,
   output slot_state_t      state,
   output logic [TAG_W-1:0] tag,
   output logic             err,
   output logic             spurious_hit
);

   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   slot_state_t      state_q;
   slot_state_t      state_d;
   logic [TMR_W-1:0] timer;
   logic             expire;

   assign expire = (timer == TMR_LAST);

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept)        state_d = S_BUSY;
         S_BUSY:  if (irq || expire) state_d = S_PEND;
         S_PEND:  if (pop)           state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      state        = state_q;
      spurious_hit = irq && (state_q != S_BUSY);
   end

   // An irq arriving in the final timer cycle still counts as a clean finish.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer <= '0;
         tag   <= '0;
         err   <= 1'b0;
      end else if (accept && (state_q == S_IDLE)) begin
         timer <= '0;
         tag   <= tag_in;
         err   <= 1'b0;
      end else if (state_q == S_BUSY) begin
         timer <= timer + 1'b1;
         if (!irq && expire) err <= 1'b1;
      end
   end

endmodule

// File: rtl/mvu_job_dispatcher.sv
// Hardware initiator for the MVU array: accepts job descriptors, starts the target MVU,
// waits for its irq (or a timeout) and returns one completion per job.
module mvu_job_dispatcher
   import mvu_pkg::*;
#(
   parameter int TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             job_valid,
   output logic             job_ready,
   input  job_desc_t        job_desc,
   output logic [N-1:0]     mvu_start,
   output mvu_cfg_t         mvu_cfg,
   input  logic [N-1:0]     mvu_irq,
   output logic             cpl_valid,
   input  logic             cpl_ready,
   output logic [ID_W-1:0]  cpl_id,
   output logic [TAG_W-1:0] cpl_tag,
   output logic             cpl_err,
   output logic             spurious
);

   // Handshakes: a descriptor / completion moves on a clock edge where valid && ready.
   // job_ready is decoded from job_desc.id alone and never looks at job_valid;
   // the completion payload is held unchanged while cpl_valid && !cpl_ready.

   slot_state_t      slot_state [N];
   logic [TAG_W-1:0] slot_tag   [N];
   logic [N-1:0]     slot_err;
   logic [N-1:0]     slot_spur;
   logic [N-1:0]     slot_accept;
   logic [N-1:0]     slot_pop;
   logic [N-1:0]     slot_pend;

   logic             id_ok;
   logic [IDX_W-1:0] idx;
   logic             accept;
   logic             bad_pending;
   logic [TAG_W-1:0] bad_tag;
   logic             bad_pop;
   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic             load_en;
   mvu_cfg_t         cfg_next;
   cpl_t             cpl_next;

   assign id_ok  = (int'(job_desc.id) < N);
   assign idx    = job_desc.id[IDX_W-1:0];
   assign accept = job_valid && job_ready;

   always_comb begin
      job_ready = 1'b0;
      if (!rst) begin
         if (id_ok) job_ready = (slot_state[idx] == S_IDLE);
         else       job_ready = !bad_pending;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_slot
      assign slot_accept[i] = accept && id_ok && (idx == IDX_W'(i));
      assign slot_pend[i]   = (slot_state[i] == S_PEND);

      mvu_dispatch_slot #(.TIMEOUT(TIMEOUT)) u_slot (
         .clk          (clk),
         .rst          (rst),
         .accept       (slot_accept[i]),
         .irq          (mvu_irq[i]),
         .pop          (slot_pop[i]),
         .tag_in       (job_desc.tag),
         .state        (slot_state[i]),
         .tag          (slot_tag[i]),
         .err          (slot_err[i]),
         .spurious_hit (slot_spur[i])
      );
   end

   // Lowest-index pending slot wins; the bad-id slot is only served when no MVU is pending.
   always_comb begin
      pick_any = 1'b0;
      pick_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (slot_pend[i]) begin
            pick_any = 1'b1;
            pick_idx = IDX_W'(i);
         end
      end
   end

   assign load_en = !cpl_valid || cpl_ready;
   assign bad_pop = load_en && !pick_any && bad_pending;

   always_comb begin
      slot_pop = '0;
      if (load_en && pick_any) slot_pop[pick_idx] = 1'b1;
   end

   always_comb begin
      cpl_next = '0;
      if (pick_any) begin
         cpl_next.id  = ID_W'(pick_idx);
         cpl_next.tag = slot_tag[pick_idx];
         cpl_next.err = slot_err[pick_idx];
      end else begin
         cpl_next.id  = ID_W'(BAD_ID);
         cpl_next.tag = bad_tag;
         cpl_next.err = 1'b1;
      end
   end

   always_comb begin
      cfg_next           = '0;
      cfg_next.wprec     = job_desc.wprec;
      cfg_next.iprec     = job_desc.iprec;
      cfg_next.oprec     = job_desc.oprec;
      cfg_next.wbase     = job_desc.wbase;
      cfg_next.ibase     = job_desc.ibase;
      cfg_next.obase     = job_desc.obase;
      cfg_next.countdown = job_desc.countdown;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mvu_start <= '0;
         mvu_cfg   <= '0;
      end else begin
         mvu_start <= slot_accept;
         mvu_cfg   <= (accept && id_ok) ? cfg_next : '0;
      end
   end

   // A bad-id job never reaches an MVU; it just parks here until its error completion goes out.
   always_ff @(posedge clk) begin
      if (rst) begin
         bad_pending <= 1'b0;
         bad_tag     <= '0;
      end else if (accept && !id_ok) begin
         bad_pending <= 1'b1;
         bad_tag     <= job_desc.tag;
      end else if (bad_pop) begin
         bad_pending <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpl_valid <= 1'b0;
         cpl_id    <= '0;
         cpl_tag   <= '0;
         cpl_err   <= 1'b0;
      end else if (load_en) begin
         cpl_valid <= pick_any || bad_pending;
         if (pick_any || bad_pending) begin
            cpl_id  <= cpl_next.id;
            cpl_tag <= cpl_next.tag;
            cpl_err <= cpl_next.err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) spurious <= 1'b0;
      else     spurious <= spurious | (|slot_spur);
   end

endmodule

// File: tb/tb_mvu_job_dispatcher.sv
// Bench for mvu_job_dispatcher: directed vector table, hand-written corner sequences and a
// randomized run against a job-level reference model.
module tb_mvu_job_dispatcher;
   import mvu_pkg::*;

   localparam int TMO = 16;
   localparam int SBW = N + $bits(mvu_cfg_t);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             job_valid = 1'b0;
   logic             job_ready;
   job_desc_t        job_desc = '0;
   logic [N-1:0]     mvu_start;
   mvu_cfg_t         mvu_cfg;
   logic [N-1:0]     mvu_irq = '0;
   logic             cpl_valid;
   logic             cpl_ready = 1'b1;
   logic [ID_W-1:0]  cpl_id;
   logic [TAG_W-1:0] cpl_tag;
   logic             cpl_err;
   logic             spurious;

   always #5 clk = ~clk;

   mvu_job_dispatcher #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready), .job_desc(job_desc),
      .mvu_start(mvu_start), .mvu_cfg(mvu_cfg), .mvu_irq(mvu_irq), .cpl_valid(cpl_valid),
      .cpl_ready(cpl_ready), .cpl_id(cpl_id), .cpl_tag(cpl_tag), .cpl_err(cpl_err),
      .spurious(spurious)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [SBW-1:0] exp_q[$];

   typedef struct {
      int           id;
      int           tag;
      int           dly;
      int           cnt;
      logic [N-1:0] exp_start;
      int           exp_id;
      logic         exp_err;
      int           exp_lat;
   } vec_t;
   vec_t tbl[7];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic job_desc_t mk_desc(int id, int tag);
      job_desc_t d;
      d.id        = ID_W'(id);
      d.tag       = TAG_W'(tag);
      d.wprec     = 4'($urandom);
      d.iprec     = 4'($urandom);
      d.oprec     = 4'($urandom);
      d.wbase     = ADDR_W'($urandom);
      d.ibase     = ADDR_W'($urandom);
      d.obase     = ADDR_W'($urandom);
      d.countdown = CNT_W'($urandom);
      return d;
   endfunction

   function automatic mvu_cfg_t cfg_of(job_desc_t d);
      mvu_cfg_t c;
      c.wprec = d.wprec;  c.iprec = d.iprec;  c.oprec = d.oprec;
      c.wbase = d.wbase;  c.ibase = d.ibase;  c.obase = d.obase;
      c.countdown = d.countdown;
      return c;
   endfunction

   task automatic send(input job_desc_t d);
      job_desc = d;
      job_valid = 1'b1;
      step();
      job_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; job_valid = 1'b0; mvu_irq = '0; cpl_ready = 1'b1;
      step(); step();
      rst = 1'b0;
   endtask

   // Randomized run: jobs are tracked as whole transactions (outstanding / finished / late).
   task automatic run_random(input int n_cyc);
      bit          out_m[N+1];
      int          acc_m[N];
      int          irq_m[N];
      logic [3:0]  tag_m[N+1];
      bit          spur_m = 0, spur_pend = 0, pv = 0, pr = 1, stim, live, acc, exp_err;
      int          accepted = 0, completed = 0, i, r, jid, mi, done_edge, left;
      logic [N-1:0] irqv;
      logic [SBW-1:0] e;
      job_desc_t   d;
      for (int k = 0; k <= N; k++) begin out_m[k] = 0; tag_m[k] = '0; end
      for (int k = 0; k < N; k++) begin acc_m[k] = 0; irq_m[k] = -1; end
      exp_q.delete();
      for (int t = 0; t < n_cyc + 60; t++) begin
         stim = (t < n_cyc);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rnd_start_cfg", {mvu_start, mvu_cfg}, e);
         end
         check("rnd_spurious", spurious, spur_m);
         if (cpl_valid && (!pv || pr)) begin
            check("rnd_cpl_id_range", cpl_id <= N, 1'b1);
            if (cpl_id <= N) begin
               i = int'(cpl_id);
               check("rnd_cpl_outstanding", out_m[i], 1'b1);
               check("rnd_cpl_tag", cpl_tag, tag_m[i]);
               if (i < N) begin
                  exp_err = (irq_m[i] < 0);
                  check("rnd_cpl_err", cpl_err, exp_err);
                  done_edge = exp_err ? acc_m[i] + TMO : irq_m[i] + 1;
                  check("rnd_cpl_not_early", (cyc - 1) >= done_edge, 1'b1);
               end else begin
                  check("rnd_bad_err", cpl_err, 1'b1);
               end
               out_m[i] = 0;
               completed++;
            end
         end
         pv = cpl_valid;
         irqv = '0;
         for (int k = 0; k < N; k++) begin
            live = out_m[k] && (irq_m[k] < 0) && (cyc >= acc_m[k]) && (cyc - acc_m[k] < TMO);
            if (stim && (live ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0))) begin
               irqv[k] = 1'b1;
               if (live) irq_m[k] = cyc;
               else      spur_pend = 1;
            end
         end
         r   = $urandom_range(0, 9);
         jid = (r < 8) ? r : $urandom_range(8, 15);
         d   = mk_desc(jid, $urandom_range(0, 15));
         job_desc  = d;
         job_valid = stim && ($urandom_range(0, 2) == 0);
         cpl_ready = stim ? ($urandom_range(0, 3) != 0) : 1'b1;
         mvu_irq   = irqv;
         #1;
         mi = (jid < N) ? jid : N;
         check("rnd_job_ready", job_ready, !out_m[mi]);
         acc = job_valid && !out_m[mi];
         e = '0;
         if (acc) begin
            out_m[mi] = 1;
            tag_m[mi] = d.tag;
            accepted++;
            if (jid < N) begin
               acc_m[jid] = cyc + 1;
               irq_m[jid] = -1;
               e = {N'(1) << jid, cfg_of(d)};
            end
         end
         exp_q.push_back(e);
         pr = cpl_ready;
         step();
         if (spur_pend) spur_m = 1;
         spur_pend = 0;
      end
      job_valid = 1'b0;
      mvu_irq   = '0;
      left = 0;
      for (int k = 0; k <= N; k++) if (out_m[k]) left++;
      check("rnd_all_drained", left, 0);
      check("rnd_cpl_count", completed, accepted);
   endtask

   initial begin
      job_desc_t d, d2;
      mvu_cfg_t  ec;
      int a, k, unstable;
      bit acc;
      logic [9:0] snap;

      tbl[0] = '{2,  5,  12, 10, 8'h04, 2, 1'b0, 14};
      tbl[1] = '{0,  3,  0,  -1, 8'h01, 0, 1'b0, 2};
      tbl[2] = '{7,  15, 15, -1, 8'h80, 7, 1'b0, 17};
      tbl[3] = '{12, 9,  -1, -1, 8'h00, 8, 1'b1, 1};
      tbl[4] = '{5,  6,  -1, -1, 8'h20, 5, 1'b1, 17};
      tbl[5] = '{8,  10, -1, -1, 8'h00, 8, 1'b1, 1};
      tbl[6] = '{4,  1,  3,  -1, 8'h10, 4, 1'b0, 5};

      // reset state
      step(); step();
      check("rst_ready", job_ready, 1'b0);
      check("rst_outputs", {mvu_start, mvu_cfg, cpl_valid, cpl_id, cpl_tag, cpl_err, spurious}, '0);
      rst = 1'b0;

      // vector table: one job at a time, latency measured from the accept edge
      for (int r = 0; r < 7; r++) begin
         d = mk_desc(tbl[r].id, tbl[r].tag);
         if (tbl[r].cnt >= 0) d.countdown = CNT_W'(tbl[r].cnt);
         job_desc = d; job_valid = 1'b1;
         #1;
         check("tbl_ready", job_ready, 1'b1);
         step();
         a = cyc; job_valid = 1'b0;
         ec = (tbl[r].exp_start != '0) ? cfg_of(d) : '0;
         check("tbl_start", mvu_start, tbl[r].exp_start);
         check("tbl_cfg", mvu_cfg, ec);
         while (!cpl_valid && (cyc - a < 40)) begin
            mvu_irq = (tbl[r].dly == cyc - a) ? (N'(1) << tbl[r].id) : '0;
            step();
            if (cyc == a + 1) check("tbl_cfg_clear", {mvu_start, mvu_cfg}, '0);
         end
         mvu_irq = '0;
         check("tbl_cpl_latency", cyc - a, tbl[r].exp_lat);
         check("tbl_cpl", {cpl_valid, cpl_id, cpl_tag, cpl_err},
               {1'b1, ID_W'(tbl[r].exp_id), TAG_W'(tbl[r].tag), tbl[r].exp_err});
         step();
         check("tbl_cpl_popped", cpl_valid, 1'b0);
      end
      check("tbl_no_spurious", spurious, 1'b0);

      // same MVU twice: second descriptor waits for the first completion
      send(mk_desc(0, 1));
      d2 = mk_desc(0, 2);
      job_desc = d2; job_valid = 1'b1;
      k = 0; acc = 0;
      while (!acc && k < 30) begin
         mvu_irq = (k == 5) ? N'(1) : '0;
         #1;
         if (job_ready) begin
            acc = 1;
            check("reissue_cycle", k, 7);
            check("reissue_after_cpl", {cpl_valid, cpl_id, cpl_tag, cpl_err}, {1'b1, 4'd0, 4'd1, 1'b0});
         end
         step(); k++;
      end
      job_valid = 1'b0; mvu_irq = '0;
      check("reissue_accepted", acc, 1'b1);
      check("reissue_start", {mvu_start, mvu_cfg}, {N'(1), cfg_of(d2)});
      mvu_irq = N'(1); step(); mvu_irq = '0; step();
      check("reissue_cpl", {cpl_valid, cpl_id, cpl_tag, cpl_err}, {1'b1, 4'd0, 4'd2, 1'b0});
      step();

      // simultaneous irqs drain in index order
      send(mk_desc(1, 11)); send(mk_desc(3, 13)); send(mk_desc(6, 14));
      step();
      mvu_irq = 8'b0100_1010; step(); mvu_irq = '0; step();
      check("multi_cpl0", {cpl_valid, cpl_id, cpl_tag}, {1'b1, 4'd1, 4'd11});
      step();
      check("multi_cpl1", {cpl_valid, cpl_id, cpl_tag}, {1'b1, 4'd3, 4'd13});
      step();
      check("multi_cpl2", {cpl_valid, cpl_id, cpl_tag}, {1'b1, 4'd6, 4'd14});
      step();
      check("multi_done", cpl_valid, 1'b0);

      // back-pressure: payload held, nothing lost
      cpl_ready = 1'b0;
      send(mk_desc(2, 7)); send(mk_desc(4, 8));
      mvu_irq = 8'b0001_0100; step(); mvu_irq = '0; step();
      snap = {cpl_valid, cpl_id, cpl_tag, cpl_err};
      check("hold_first", snap, {1'b1, 4'd2, 4'd7, 1'b0});
      unstable = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if ({cpl_valid, cpl_id, cpl_tag, cpl_err} !== snap) unstable++;
      end
      check("hold_stable", unstable, 0);
      cpl_ready = 1'b1;
      step();
      check("hold_second", {cpl_valid, cpl_id, cpl_tag, cpl_err}, {1'b1, 4'd4, 4'd8, 1'b0});
      step();
      check("hold_done", cpl_valid, 1'b0);

      // late irq after the timeout of MVU5 (table row) is spurious
      check("spur_before", spurious, 1'b0);
      mvu_irq = 8'h20; step(); mvu_irq = '0;
      check("spur_after", spurious, 1'b1);
      step();
      check("spur_sticky", spurious, 1'b1);

      // reset with one job in flight and one completion waiting
      cpl_ready = 1'b0;
      send(mk_desc(1, 2)); send(mk_desc(3, 4));
      mvu_irq = 8'h02; step(); mvu_irq = '0; step();
      check("pre_rst_cpl", cpl_valid, 1'b1);
      rst = 1'b1;
      job_desc = mk_desc(3, 0);
      step();
      check("mid_rst_outputs", {mvu_start, mvu_cfg, cpl_valid, cpl_id, cpl_tag, cpl_err, spurious}, '0);
      check("mid_rst_ready", job_ready, 1'b0);
      step();
      rst = 1'b0; cpl_ready = 1'b1;
      #1;
      check("post_rst_ready", job_ready, 1'b1);
      unstable = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (cpl_valid || (mvu_start != '0)) unstable++;
      end
      check("post_rst_quiet", unstable, 0);

      do_reset();
      run_random(3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
